// File: rtl/bypass_ctrl_pkg.sv
// Shared constants for the operand-bypass controller: register-file
// address width, source-select codes for the operand mux, and the
// encoding of a pipeline bubble.
package bypass_ctrl_pkg;

    // Register-file address width (16 registers) and stall-counter width.
    localparam int RF_AW_DEF = 4;
    localparam int CNT_W_DEF = 16;

    // Operand source-select codes seen by the source mux.
    typedef enum logic [1:0] {
        SRC_RF = 2'd0,
        SRC_EX = 2'd1,
        SRC_DM = 2'd2
    } src_sel_e;

    // A bubble neither writes the register file nor counts as a load.
    localparam logic BUBBLE_WE = 1'b0;
    localparam logic BUBBLE_LD = 1'b0;

endpackage

// File: rtl/hazard_cmp.sv
// Per-read-port hazard compare. The decoded instruction's source is
// matched against the producers now in ID_EX (one ahead) and EX_DM
// (two ahead). R0 is hardwired zero and never matches.
module hazard_cmp #(
    parameter int AW = 4
) (
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic          we_id_ex,
    input  logic          ld_id_ex,
    input  logic [AW-1:0] dst_id_ex,
    input  logic          we_ex_dm,
    input  logic [AW-1:0] dst_ex_dm,
    output logic          match_id_ex,
    output logic          hit_ex,
    output logic          hit_dm
);

    logic active;

    assign active      = re & (addr != '0);
    // Raw match against ID_EX; a load there cannot forward and stalls instead.
    assign match_id_ex = active & we_id_ex & (dst_id_ex == addr);
    assign hit_ex      = match_id_ex & ~ld_id_ex;
    // EX_DM forwards regardless of load: load data is ready by DM_WB.
    assign hit_dm      = active & we_ex_dm & (dst_ex_dm == addr);

endmodule

// File: rtl/bypass_ctrl.sv
// Operand-bypass and load-use stall controller. Tracks the write
// destinations of the three instructions ahead of decode and produces
// registered bypass selects aligned with the consumer's ID_EX cycle.
module bypass_ctrl
    import bypass_ctrl_pkg::*;
#(
    parameter int RF_AW = RF_AW_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_pipe,
    input  logic             flush_ID_EX,
    input  logic             re0_IF_ID,
    input  logic             re1_IF_ID,
    input  logic [RF_AW-1:0] p0_addr,
    input  logic [RF_AW-1:0] p1_addr,
    input  logic [RF_AW-1:0] dst_addr,
    input  logic             we_IF_ID,
    input  logic             ld_IF_ID,
    input  logic             clr_cnt,
    output logic             byp0_EX,
    output logic             byp0_DM,
    output logic             byp1_EX,
    output logic             byp1_DM,
    output logic             stall_IF_ID,
    output logic [RF_AW-1:0] dst_addr_DM_WB,
    output logic             we_DM_WB,
    output logic [CNT_W-1:0] stall_cnt
);

    // Producer pipeline entries {we, ld, dst}.
    logic             we_id_ex, ld_id_ex;
    logic [RF_AW-1:0] dst_id_ex;
    logic             we_ex_dm, ld_ex_dm;
    logic [RF_AW-1:0] dst_ex_dm;
    logic             we_dm_wb, ld_dm_wb;
    logic [RF_AW-1:0] dst_dm_wb;

    logic match0, hit0_ex, hit0_dm;
    logic match1, hit1_ex, hit1_dm;

    hazard_cmp #(.AW(RF_AW)) u_cmp0 (
        .re          (re0_IF_ID),
        .addr        (p0_addr),
        .we_id_ex    (we_id_ex),
        .ld_id_ex    (ld_id_ex),
        .dst_id_ex   (dst_id_ex),
        .we_ex_dm    (we_ex_dm),
        .dst_ex_dm   (dst_ex_dm),
        .match_id_ex (match0),
        .hit_ex      (hit0_ex),
        .hit_dm      (hit0_dm)
    );

    hazard_cmp #(.AW(RF_AW)) u_cmp1 (
        .re          (re1_IF_ID),
        .addr        (p1_addr),
        .we_id_ex    (we_id_ex),
        .ld_id_ex    (ld_id_ex),
        .dst_id_ex   (dst_id_ex),
        .we_ex_dm    (we_ex_dm),
        .dst_ex_dm   (dst_ex_dm),
        .match_id_ex (match1),
        .hit_ex      (hit1_ex),
        .hit_dm      (hit1_dm)
    );

    // Load in ID_EX feeding the decoded instruction: hold decode one cycle.
    assign stall_IF_ID    = ld_id_ex & we_id_ex & (match0 | match1);
    assign dst_addr_DM_WB = dst_dm_wb;
    assign we_DM_WB       = we_dm_wb;

    // Pipeline advance, bypass-select registers and stall counter; a
    // global freeze holds everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_id_ex  <= 1'b0;
            ld_id_ex  <= 1'b0;
            dst_id_ex <= '0;
            we_ex_dm  <= 1'b0;
            ld_ex_dm  <= 1'b0;
            dst_ex_dm <= '0;
            we_dm_wb  <= 1'b0;
            ld_dm_wb  <= 1'b0;
            dst_dm_wb <= '0;
            byp0_EX   <= 1'b0;
            byp0_DM   <= 1'b0;
            byp1_EX   <= 1'b0;
            byp1_DM   <= 1'b0;
            stall_cnt <= '0;
        end else if (!stall_pipe) begin
            if (flush_ID_EX || stall_IF_ID) begin
                we_id_ex  <= BUBBLE_WE;
                ld_id_ex  <= BUBBLE_LD;
                dst_id_ex <= '0;
                byp0_EX   <= 1'b0;
                byp0_DM   <= 1'b0;
                byp1_EX   <= 1'b0;
                byp1_DM   <= 1'b0;
            end else begin
                we_id_ex  <= we_IF_ID;
                ld_id_ex  <= ld_IF_ID;
                dst_id_ex <= dst_addr;
                byp0_EX   <= hit0_ex;
                byp0_DM   <= hit0_dm & ~hit0_ex;
                byp1_EX   <= hit1_ex;
                byp1_DM   <= hit1_dm & ~hit1_ex;
            end
            we_ex_dm  <= we_id_ex;
            ld_ex_dm  <= ld_id_ex;
            dst_ex_dm <= dst_id_ex;
            we_dm_wb  <= we_ex_dm;
            ld_dm_wb  <= ld_ex_dm;
            dst_dm_wb <= dst_ex_dm;
            if (clr_cnt) begin
                stall_cnt <= '0;
            end else if (stall_IF_ID && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    // The load flag past DM_WB has no consumer; fold it in so it is not dangling.
    logic unused_ok;
    assign unused_ok = ld_dm_wb;

endmodule

// File: tb/tb_bypass_ctrl.sv
// Directed bench for bypass_ctrl: hand-computed instruction sequences
// covering EX/DM forwarding, load-use stalls, R0, global freeze, flush,
// reset mid-stall and counter saturation/clear.
module tb_bypass_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall_pipe, flush_ID_EX, re0_IF_ID, re1_IF_ID;
  logic [3:0] p0_addr, p1_addr, dst_addr;
  logic       we_IF_ID, ld_IF_ID, clr_cnt;
  logic       byp0_EX, byp0_DM, byp1_EX, byp1_DM, stall_IF_ID, we_DM_WB;
  logic [3:0] dst_addr_DM_WB;
  logic [15:0] stall_cnt;

  // Narrow-counter instance sharing the same stimulus, for saturation.
  logic       s_b0e, s_b0d, s_b1e, s_b1d, s_stall, s_we;
  logic [3:0] s_dst;
  logic [3:0] s_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  bypass_ctrl dut (
    .clk(clk), .rst_n(rst_n), .stall_pipe(stall_pipe), .flush_ID_EX(flush_ID_EX),
    .re0_IF_ID(re0_IF_ID), .re1_IF_ID(re1_IF_ID), .p0_addr(p0_addr), .p1_addr(p1_addr),
    .dst_addr(dst_addr), .we_IF_ID(we_IF_ID), .ld_IF_ID(ld_IF_ID), .clr_cnt(clr_cnt),
    .byp0_EX(byp0_EX), .byp0_DM(byp0_DM), .byp1_EX(byp1_EX), .byp1_DM(byp1_DM),
    .stall_IF_ID(stall_IF_ID), .dst_addr_DM_WB(dst_addr_DM_WB), .we_DM_WB(we_DM_WB),
    .stall_cnt(stall_cnt)
  );

  bypass_ctrl #(.RF_AW(4), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .stall_pipe(stall_pipe), .flush_ID_EX(flush_ID_EX),
    .re0_IF_ID(re0_IF_ID), .re1_IF_ID(re1_IF_ID), .p0_addr(p0_addr), .p1_addr(p1_addr),
    .dst_addr(dst_addr), .we_IF_ID(we_IF_ID), .ld_IF_ID(ld_IF_ID), .clr_cnt(clr_cnt),
    .byp0_EX(s_b0e), .byp0_DM(s_b0d), .byp1_EX(s_b1e), .byp1_DM(s_b1d),
    .stall_IF_ID(s_stall), .dst_addr_DM_WB(s_dst), .we_DM_WB(s_we),
    .stall_cnt(s_cnt)
  );

  // Clock: period 10, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bypass selects packed as {byp0_EX, byp0_DM, byp1_EX, byp1_DM}.
  task automatic check_byp(input string tag, input logic [3:0] exp);
    check(tag, 32'({byp0_EX, byp0_DM, byp1_EX, byp1_DM}), 32'(exp));
  endtask

  // Present a decoded instruction in IF_ID.
  task automatic issue(input logic r0, input logic [3:0] a0, input logic r1,
                       input logic [3:0] a1, input logic we, input logic ld,
                       input logic [3:0] dst);
    re0_IF_ID = r0; p0_addr = a0;
    re1_IF_ID = r1; p1_addr = a1;
    we_IF_ID  = we; ld_IF_ID = ld; dst_addr = dst;
  endtask

  task automatic nop();
    issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
  endtask

  // One rising edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) step();
  endtask

  initial begin
    rst_n = 1'b0; stall_pipe = 1'b0; flush_ID_EX = 1'b0; clr_cnt = 1'b0;
    nop();
    #12;
    check_byp("reset_byp", 4'b0000);
    check("reset_stall", 32'(stall_IF_ID), 32'd0);
    check("reset_wb", 32'({we_DM_WB, dst_addr_DM_WB}), 32'd0);
    check("reset_cnt", 32'(stall_cnt), 32'd0);
    rst_n = 1'b1;

    // ADD R3,R1,R2 then ADD R5,R3,R4: EX bypass on port 0.
    issue(1, 4'd1, 1, 4'd2, 1, 0, 4'd3);
    step();
    check_byp("first_instr_no_hit", 4'b0000);
    issue(1, 4'd3, 1, 4'd4, 1, 0, 4'd5);
    #1 check("add_add_no_stall", 32'(stall_IF_ID), 32'd0);
    step();
    check_byp("add_add_ex", 4'b1000);
    nop();
    step();
    check("wb_dst_r3", 32'({we_DM_WB, dst_addr_DM_WB}), 32'h13);
    drain();

    // ADD R3; NOP; SUB R6,R2,R3: DM bypass on port 1.
    issue(1, 4'd1, 1, 4'd2, 1, 0, 4'd3);
    step();
    nop();
    step();
    issue(1, 4'd2, 1, 4'd3, 1, 0, 4'd6);
    step();
    check_byp("gap_dm_port1", 4'b0001);
    drain();

    // Two producers of R3 ahead: EX wins.
    issue(1, 4'd1, 1, 4'd2, 1, 0, 4'd3);
    step();
    issue(1, 4'd1, 0, 4'd0, 1, 0, 4'd3);
    step();
    issue(1, 4'd2, 1, 4'd3, 1, 0, 4'd6);
    step();
    check_byp("ex_priority", 4'b0010);
    drain();

    // LW R7 then ADD R1,R7,R2: one stall cycle, bubble, then DM bypass.
    issue(1, 4'd1, 0, 4'd0, 1, 1, 4'd7);
    #1 check("lw_no_stall", 32'(stall_IF_ID), 32'd0);
    step();
    issue(1, 4'd7, 1, 4'd2, 1, 0, 4'd1);
    #1 check("load_use_stall", 32'(stall_IF_ID), 32'd1);
    step();
    check_byp("stall_bubble_byp", 4'b0000);
    check("stall_cnt_1", 32'(stall_cnt), 32'd1);
    check("stall_released", 32'(stall_IF_ID), 32'd0);
    step();
    check_byp("load_use_dm", 4'b0100);
    check("stall_cnt_still_1", 32'(stall_cnt), 32'd1);
    drain();

    // Producer and consumer on R0, both ALU and load producers.
    issue(0, 4'd0, 0, 4'd0, 1, 0, 4'd0);
    step();
    issue(1, 4'd0, 1, 4'd0, 1, 1, 4'd0);
    #1 check("r0_alu_no_stall", 32'(stall_IF_ID), 32'd0);
    step();
    check_byp("r0_alu_no_byp", 4'b0000);
    issue(1, 4'd0, 1, 4'd0, 1, 0, 4'd2);
    #1 check("r0_load_no_stall", 32'(stall_IF_ID), 32'd0);
    step();
    check_byp("r0_load_no_byp", 4'b0000);
    drain();

    // Global freeze during a load-use stall with byp0_EX set.
    issue(0, 4'd0, 0, 4'd0, 1, 0, 4'd3);
    step();
    issue(1, 4'd3, 1, 4'd4, 1, 0, 4'd5);
    step();
    issue(1, 4'd5, 0, 4'd0, 1, 1, 4'd7);
    step();
    check_byp("lw_addr_ex", 4'b1000);
    issue(1, 4'd7, 1, 4'd2, 1, 0, 4'd1);
    stall_pipe = 1'b1;
    #1 check("freeze_stall_comb", 32'(stall_IF_ID), 32'd1);
    repeat (3) step();
    check_byp("freeze_byp_held", 4'b1000);
    check("freeze_cnt_held", 32'(stall_cnt), 32'd1);
    check("freeze_stall_held", 32'(stall_IF_ID), 32'd1);
    stall_pipe = 1'b0;
    step();
    check_byp("unfreeze_bubble", 4'b0000);
    check("unfreeze_cnt_2", 32'(stall_cnt), 32'd2);
    step();
    check_byp("unfreeze_dm", 4'b0100);
    drain();

    // Flush with a pending EX match, then DM still seen past the bubble.
    issue(1, 4'd1, 1, 4'd2, 1, 0, 4'd3);
    step();
    issue(1, 4'd3, 0, 4'd0, 1, 0, 4'd5);
    flush_ID_EX = 1'b1;
    step();
    flush_ID_EX = 1'b0;
    check_byp("flush_clears", 4'b0000);
    issue(1, 4'd3, 0, 4'd0, 1, 0, 4'd6);
    step();
    check_byp("after_flush_dm", 4'b0100);
    drain();

    // Reset pulsed during a load-use stall.
    issue(0, 4'd0, 0, 4'd0, 1, 1, 4'd7);
    step();
    issue(1, 4'd7, 0, 4'd0, 1, 0, 4'd1);
    #1 check("pre_reset_stall", 32'(stall_IF_ID), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_stall", 32'(stall_IF_ID), 32'd0);
    check("async_reset_cnt", 32'(stall_cnt), 32'd0);
    check_byp("async_reset_byp", 4'b0000);
    check("async_reset_wb", 32'({we_DM_WB, dst_addr_DM_WB}), 32'd0);
    #1 rst_n = 1'b1;
    step();
    check_byp("post_reset_no_hazard", 4'b0000);
    check("post_reset_cnt", 32'(stall_cnt), 32'd0);
    drain();

    // 17 load-use stalls: 4-bit counter saturates at 15, 16-bit reads 17.
    for (int i = 0; i < 18; i++) begin
      issue(0, 4'd0, 0, 4'd0, 1, 1, 4'd7);
      step();
      issue(1, 4'd7, 0, 4'd0, 0, 0, 4'd0);
      step();
      if (i == 16) begin
        check("cnt_17", 32'(stall_cnt), 32'd17);
        check("small_sat_15", 32'(s_cnt), 32'd15);
      end
    end
    check("small_sat_hold", 32'(s_cnt), 32'd15);
    check("cnt_18", 32'(stall_cnt), 32'd18);

    // Clear with a concurrent stall: clear wins.
    issue(0, 4'd0, 0, 4'd0, 1, 1, 4'd7);
    step();
    issue(1, 4'd7, 0, 4'd0, 0, 0, 4'd0);
    clr_cnt = 1'b1;
    #1 check("clr_stall_active", 32'(stall_IF_ID), 32'd1);
    step();
    clr_cnt = 1'b0;
    check("clr_wins", 32'(stall_cnt), 32'd0);
    check("clr_wins_small", 32'(s_cnt), 32'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1);
  end

endmodule
